// File: rtl/mem_lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
// Size codes, FSM states and the alignment check.
package mem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } lsu_state_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      (size == SZ_BYTE): bad = 1'b0;
      (size == SZ_HALF): bad = lo[0];
      (size == SZ_WORD): bad = (lo != 2'd0);
      default:           bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit.
// Load: extract and extend. Store: merge into old word.
module lsu_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [31:0] i_ld_word,
  input  logic [1:0]  i_ld_lo,
  input  logic [1:0]  i_ld_size,
  input  logic        i_ld_unsigned,
  output logic [31:0] o_ld_data,
  input  logic [31:0] i_st_old,
  input  logic [15:0] i_st_data,
  input  logic [1:0]  i_st_lo,
  input  logic [1:0]  i_st_size,
  output logic [31:0] o_st_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_ld_word[7:0];
    unique case (i_ld_lo)
      2'd0: w_byte = i_ld_word[7:0];
      2'd1: w_byte = i_ld_word[15:8];
      2'd2: w_byte = i_ld_word[23:16];
      2'd3: w_byte = i_ld_word[31:24];
      default: w_byte = i_ld_word[7:0];
    endcase
    w_half = i_ld_lo[1] ? i_ld_word[31:16]
                        : i_ld_word[15:0];
  end

  always_comb begin
    o_ld_data = i_ld_word;
    unique case (1'b1)
      (i_ld_size == SZ_BYTE):
        o_ld_data = i_ld_unsigned
          ? {24'd0, w_byte}
          : {{24{w_byte[7]}}, w_byte};
      (i_ld_size == SZ_HALF):
        o_ld_data = i_ld_unsigned
          ? {16'd0, w_half}
          : {{16{w_half[15]}}, w_half};
      default:
        o_ld_data = i_ld_word;
    endcase
  end

  always_comb begin
    o_st_word = i_st_old;
    unique case (1'b1)
      (i_st_size == SZ_BYTE): begin
        unique case (i_st_lo)
          2'd0: o_st_word[7:0]   = i_st_data[7:0];
          2'd1: o_st_word[15:8]  = i_st_data[7:0];
          2'd2: o_st_word[23:16] = i_st_data[7:0];
          2'd3: o_st_word[31:24] = i_st_data[7:0];
          default: o_st_word = i_st_old;
        endcase
      end
      (i_st_size == SZ_HALF): begin
        if (i_st_lo[1])
          o_st_word[31:16] = i_st_data;
        else
          o_st_word[15:0] = i_st_data;
      end
      default: o_st_word = i_st_old;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of the 4K x 32 data RAM.
// Sub-word stores use a one-cycle read-modify-write.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wd,
  input  logic [31:0]       ram_rd
);

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [15:0]       r_wdata;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_err;

  logic        w_acc;
  logic        w_err;
  logic        w_we;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign req_ready = (r_state == ST_IDLE);
  assign w_acc     = req_valid & req_ready;
  assign w_err     = misaligned(req_size, req_addr[1:0]);

  lsu_lane_align u_align (
    .i_ld_word     (ram_rd),
    .i_ld_lo       (req_addr[1:0]),
    .i_ld_size     (req_size),
    .i_ld_unsigned (req_unsigned),
    .o_ld_data     (w_load),
    .i_st_old      (ram_rd),
    .i_st_data     (r_wdata),
    .i_st_lo       (r_addr[1:0]),
    .i_st_size     (r_size),
    .o_st_word     (w_merged)
  );

  always_comb begin
    w_next   = r_state;
    w_we     = 1'b0;
    ram_addr = req_addr;
    ram_wd   = 32'd0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_acc && !w_err && req_we) begin
          if (req_size == SZ_WORD) begin
            w_we   = 1'b1;
            ram_wd = req_wdata;
          end else begin
            w_next = ST_RMW;
          end
        end
      end
      ST_RMW: begin
        ram_addr = r_addr;
        ram_wd   = w_merged;
        w_we     = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Reset must never let an aborted RMW reach the RAM.
  assign ram_we = w_we & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_size       <= 2'd0;
      r_wdata      <= 16'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_resp_valid <= 1'b0;
      if (r_state == ST_RMW) begin
        r_resp_valid <= 1'b1;
        r_resp_rdata <= 32'd0;
        r_resp_err   <= 1'b0;
      end else if (w_acc) begin
        if (w_err) begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= 32'd0;
          r_resp_err   <= 1'b1;
        end else if (!req_we) begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_load;
          r_resp_err   <= 1'b0;
        end else if (req_size == SZ_WORD) begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= 32'd0;
          r_resp_err   <= 1'b0;
        end else begin
          r_addr  <= req_addr;
          r_size  <= req_size;
          r_wdata <= req_wdata[15:0];
        end
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu with a RAM model
// and an array-based reference memory.
module tb_mem_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wd;
  logic [31:0] ram_rd;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];

  mem_lsu #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wd       (ram_wd),
    .ram_rd       (ram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rd = mem[ram_addr[13:2]];

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr[13:2]] <= ram_wd;
      we_cnt <= we_cnt + 1;
    end
  end

  function automatic logic model_err(logic [1:0] sz, logic [1:0] lo);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1) return lo[0];
    if (sz == 2'd2) return lo != 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(
    logic [31:0] w, logic [1:0] lo, logic [1:0] sz, logic uns);
    int sh;
    logic [31:0] v;
    sh = int'(lo) * 8;
    v = w >> sh;
    if (sz == 2'd0)
      return uns ? (v & 32'hFF) : {{24{v[7]}}, v[7:0]};
    if (sz == 2'd1)
      return uns ? (v & 32'hFFFF) : {{16{v[15]}}, v[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] model_store(
    logic [31:0] old, logic [31:0] wd, logic [1:0] lo, logic [1:0] sz);
    int sh;
    logic [31:0] m;
    sh = int'(lo) * 8;
    m = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    return (old & ~(m << sh)) | ((wd & m) << sh);
  endfunction

  // Drive one request (at posedge+1) and wait for its response.
  task automatic issue(
    input  logic        we,
    input  logic [1:0]  sz,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output int          lat,
    output logic [31:0] rd,
    output logic        err,
    output int          wes,
    output logic        rdy_after
  );
    int w0;
    w0 = we_cnt;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    @(posedge clk); #1;
    rdy_after    = req_ready;
    req_valid    = 1'b0;
    req_we       = $urandom_range(0, 1);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    lat = 1;
    while (!resp_valid && lat < 5) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = resp_rdata;
    err = resp_err;
    wes = we_cnt - w0;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h0000_0040;
    req_wdata = 32'h1234_5678;
    req_unsigned = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_ram_we got %b want 0", ram_we);
    end
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== 34'd0) begin
      errors++;
      $display("FAIL reset_resp got v=%b e=%b d=%h want 0",
               resp_valid, resp_err, resp_rdata);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", req_ready);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loads;
    logic [31:0] rd;
    logic err, rdy;
    int lat, wes;
    logic [31:0] exp_d [6];
    logic [31:0] ad [6];
    logic [1:0]  sz [6];
    logic        un [6];
    mem[12'h040] = 32'h8081_7F02;
    ref_mem[12'h040] = 32'h8081_7F02;
    ad = '{32'h101, 32'h103, 32'h103, 32'h102, 32'h102, 32'h101};
    sz = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    un = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_d = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0080,
              32'hFFFF_8081, 32'h0000_8081, 32'h0000_0000};
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, sz[i], un[i], ad[i], 32'h0, lat, rd, err, wes, rdy);
      checks++;
      if (rd !== exp_d[i] || lat != 1 || err !== (i == 5) || wes != 0) begin
        errors++;
        $display("FAIL load_%0d got d=%h lat=%0d e=%b we=%0d want d=%h lat=1 e=%b we=0",
                 i, rd, lat, err, wes, exp_d[i], (i == 5));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    logic err, rdy;
    int lat, wes;
    issue(1'b1, 2'd2, 1'b0, 32'h200, 32'hDEAD_BEEF, lat, rd, err, wes, rdy);
    checks++;
    if (lat != 1 || wes != 1 || rd !== 32'd0 || err !== 1'b0 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL sw got lat=%0d we=%0d d=%h e=%b rdy=%b want 1 1 0 0 1",
               lat, wes, rd, err, rdy);
    end
    ref_mem[12'h080] = 32'hDEAD_BEEF;
    issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, lat, rd, err, wes, rdy);
    checks++;
    if (rd !== 32'hDEAD_BEEF || lat != 1) begin
      errors++;
      $display("FAIL lw_b2b got %h lat=%0d want deadbeef lat=1", rd, lat);
    end
  endtask

  task automatic test_rmw;
    logic [31:0] rd;
    logic err, rdy;
    int lat, wes;
    mem[12'h0C0] = 32'h1122_3344;
    ref_mem[12'h0C0] = 32'h1122_3344;
    issue(1'b1, 2'd0, 1'b0, 32'h302, 32'h0000_00AA, lat, rd, err, wes, rdy);
    checks++;
    if (lat != 2 || wes != 1 || rdy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL sb_timing got lat=%0d we=%0d rdy=%b e=%b want 2 1 0 0",
               lat, wes, rdy, err);
    end
    checks++;
    if (mem[12'h0C0] !== 32'h11AA_3344) begin
      errors++;
      $display("FAIL sb_word got %h want 11aa3344", mem[12'h0C0]);
    end
    issue(1'b1, 2'd1, 1'b0, 32'h300, 32'hFFFF_5566, lat, rd, err, wes, rdy);
    issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, lat, rd, err, wes, rdy);
    checks++;
    if (rd !== 32'h11AA_5566) begin
      errors++;
      $display("FAIL sh_word got %h want 11aa5566", rd);
    end
    ref_mem[12'h0C0] = 32'h11AA_5566;
  endtask

  task automatic test_rmw_reset_abort;
    int w0;
    mem[12'h0D0] = 32'hCAFE_F00D;
    ref_mem[12'h0D0] = 32'hCAFE_F00D;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd0;
    req_addr  = 32'h341;
    req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    w0 = we_cnt;
    #1;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL abort_ram_we got %b want 0", ram_we);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (we_cnt != w0 || mem[12'h0D0] !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL abort_word got %h writes=%0d want cafef00d 0",
               mem[12'h0D0], we_cnt - w0);
    end
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_state got v=%b rdy=%b want 0 1", resp_valid, req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_errors;
    logic [31:0] rd;
    logic err, rdy;
    int lat, wes;
    mem[12'h100] = 32'h0BAD_0BAD;
    ref_mem[12'h100] = 32'h0BAD_0BAD;
    issue(1'b1, 2'd2, 1'b0, 32'h402, 32'hFFFF_FFFF, lat, rd, err, wes, rdy);
    checks++;
    if (err !== 1'b1 || rd !== 32'd0 || wes != 0 || lat != 1) begin
      errors++;
      $display("FAIL sw_mis got e=%b d=%h we=%0d lat=%0d want 1 0 0 1",
               err, rd, wes, lat);
    end
    issue(1'b1, 2'd3, 1'b0, 32'h400, 32'hFFFF_FFFF, lat, rd, err, wes, rdy);
    checks++;
    if (err !== 1'b1 || rd !== 32'd0 || wes != 0 || lat != 1) begin
      errors++;
      $display("FAIL size3 got e=%b d=%h we=%0d lat=%0d want 1 0 0 1",
               err, rd, wes, lat);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, lat, rd, err, wes, rdy);
    checks++;
    if (err !== 1'b0 || rd !== 32'h0BAD_0BAD || lat != 1) begin
      errors++;
      $display("FAIL lw_after_err got e=%b d=%h lat=%0d want 0 0bad0bad 1",
               err, rd, lat);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, a, wd, exp_d;
    logic err, rdy, we, un, exp_e;
    logic [1:0] sz;
    int lat, wes, exp_lat, exp_w, idx;
    for (int i = 0; i < 300; i++) begin
      a  = 32'h800 + 32'($urandom_range(0, 31));
      sz = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      un = 1'($urandom_range(0, 1));
      wd = $urandom;
      idx = int'(a[13:2]);
      exp_e = model_err(sz, a[1:0]);
      exp_d = (exp_e || we) ? 32'd0
            : model_load(ref_mem[idx], a[1:0], sz, un);
      exp_lat = (!exp_e && we && sz != 2'd2) ? 2 : 1;
      exp_w = (!exp_e && we) ? 1 : 0;
      issue(we, sz, un, a, wd, lat, rd, err, wes, rdy);
      if (exp_w == 1)
        ref_mem[idx] = model_store(ref_mem[idx], wd, a[1:0], sz);
      checks++;
      if (rd !== exp_d || err !== exp_e || lat != exp_lat || wes != exp_w) begin
        errors++;
        $display("FAIL rand_%0d a=%h sz=%0d we=%b got d=%h e=%b lat=%0d w=%0d want d=%h e=%b lat=%0d w=%0d",
                 i, a, sz, we, rd, err, lat, wes, exp_d, exp_e, exp_lat, exp_w);
      end
    end
    for (int j = 512; j < 520; j++) begin
      checks++;
      if (mem[j] !== ref_mem[j]) begin
        errors++;
        $display("FAIL rand_mem_%0d got %h want %h", j, mem[j], ref_mem[j]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4096; k++) begin
      mem[k] = $urandom;
      ref_mem[k] = mem[k];
    end
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    @(posedge clk); #1;
    test_reset();
    test_loads();
    test_back_to_back();
    test_rmw();
    test_rmw_reset_abort();
    test_errors();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
